fu_ctrl: RTL and testbench

Command-driven sequencer that owns a small register file and drives the registered ALU/shifter functional unit (one-cycle result latency, N/C/V/Z flags). It accepts commands over a valid/ready handshake, reads operands from its register file, issues them to the functional unit, and writes results and flags back. It sits between the instruction/test front end and the functional unit, and is the only master of the unit's operand and op inputs.

---
 rtl/fu_pkg.sv | 36 +++
 rtl/fu_ctrl_if.sv | 46 ++++
 rtl/fu_regfile.sv | 35 +++
 rtl/fu_ctrl.sv | 127 ++++++++++++
 tb/tb_fu_ctrl.sv | 436 ++++++++++++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/fu_pkg.sv
// Shared definitions for the functional-unit command sequencer.
// Command kinds, FSM state encoding and flag bit positions.
package fu_pkg;

    localparam logic [1:0] CMD_EXEC  = 2'b00;
    localparam logic [1:0] CMD_LOADI = 2'b01;
    localparam logic [1:0] CMD_READ  = 2'b10;
    localparam logic [1:0] CMD_RSVD  = 2'b11;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'b00,
        ST_ISSUE = 2'b01,
        ST_WB    = 2'b10
    } state_t;

    localparam int FLAG_N = 3;
    localparam int FLAG_C = 2;
    localparam int FLAG_V = 1;
    localparam int FLAG_Z = 0;

    function automatic logic [3:0] pack_flags(
        input logic n,
        input logic c,
        input logic v,
        input logic z
    );
        logic [3:0] f;
        f         = '0;
        f[FLAG_N] = n;
        f[FLAG_C] = c;
        f[FLAG_V] = v;
        f[FLAG_Z] = z;
        return f;
    endfunction

endpackage

// File: rtl/fu_ctrl_if.sv
// Command/response bundle between the front end and fu_ctrl.
// The front end is the master; the controller is the slave.
interface fu_ctrl_if #(
    parameter int OPSIZE = 5,
    parameter int DSIZE  = 16,
    parameter int AW     = 3
) ();

    logic              cmd_valid;
    logic              cmd_ready;
    logic [1:0]        cmd_kind;
    logic [OPSIZE-1:0] cmd_op;
    logic [AW-1:0]     cmd_ra;
    logic [AW-1:0]     cmd_rb;
    logic [AW-1:0]     cmd_rd;
    logic [DSIZE-1:0]  cmd_imm;
    logic              rsp_valid;
    logic [DSIZE-1:0]  rsp_data;

    modport master (
        output cmd_valid,
        output cmd_kind,
        output cmd_op,
        output cmd_ra,
        output cmd_rb,
        output cmd_rd,
        output cmd_imm,
        input  cmd_ready,
        input  rsp_valid,
        input  rsp_data
    );

    modport slave (
        input  cmd_valid,
        input  cmd_kind,
        input  cmd_op,
        input  cmd_ra,
        input  cmd_rb,
        input  cmd_rd,
        input  cmd_imm,
        output cmd_ready,
        output rsp_valid,
        output rsp_data
    );

endinterface

// File: rtl/fu_regfile.sv
// Register file: two combinational read ports, one clocked write
// port, whole array cleared by the asynchronous reset.
module fu_regfile #(
    parameter int DSIZE = 16,
    parameter int AW    = 3
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [AW-1:0]    ra_a,
    input  logic [AW-1:0]    ra_b,
    output logic [DSIZE-1:0] rd_a,
    output logic [DSIZE-1:0] rd_b,
    input  logic             we,
    input  logic [AW-1:0]    wa,
    input  logic [DSIZE-1:0] wd
);

    localparam int NREG = 2 ** AW;

    logic [DSIZE-1:0] mem [NREG];

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < NREG; i++) begin
                mem[i] <= '0;
            end
        end else if (we) begin
            mem[wa] <= wd;
        end
    end

    assign rd_a = mem[ra_a];
    assign rd_b = mem[ra_b];

endmodule

// File: rtl/fu_ctrl.sv
// Command sequencer that owns the register file and drives the
// registered ALU/shifter unit: EXEC, LOADI, READ over valid/ready.
module fu_ctrl
    import fu_pkg::*;
#(
    parameter int OPSIZE = 5,
    parameter int DSIZE  = 16,
    parameter int AW     = 3
) (
    input  logic              clk,
    input  logic              rst_n,
    fu_ctrl_if.slave          cif,
    output logic [3:0]        flags,
    output logic [OPSIZE-1:0] fu_op,
    output logic [DSIZE-1:0]  fu_a,
    output logic [DSIZE-1:0]  fu_b,
    input  logic [DSIZE-1:0]  fu_f,
    input  logic              fu_n,
    input  logic              fu_c,
    input  logic              fu_v,
    input  logic              fu_z
);

    state_t state;
    state_t nxt;

    logic st_idle;
    logic st_issue;
    logic st_wb;
    logic hs;
    logic k_exec;
    logic k_loadi;
    logic k_read;

    logic [AW-1:0]    rd_q;
    logic             rd_pend;
    logic [DSIZE-1:0] rd_data_q;

    logic [AW-1:0]    rf_ra;
    logic [DSIZE-1:0] rf_da;
    logic [DSIZE-1:0] rf_db;
    logic             rf_we;
    logic [AW-1:0]    rf_wa;
    logic [DSIZE-1:0] rf_wd;

    assign st_idle  = (state == ST_IDLE);
    assign st_issue = (state == ST_ISSUE);
    assign st_wb    = (state == ST_WB);

    // Accept decode uses the state directly rather than cmd_ready
    assign hs      = cif.cmd_valid & st_idle;
    assign k_exec  = hs & (cif.cmd_kind == CMD_EXEC);
    assign k_loadi = hs & (cif.cmd_kind == CMD_LOADI);
    assign k_read  = hs & (cif.cmd_kind == CMD_READ);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= ST_IDLE;
        end else begin
            state <= nxt;
        end
    end

    always_comb begin
        nxt = state;
        unique case (1'b1)
            st_idle:  nxt = k_exec ? ST_ISSUE : ST_IDLE;
            st_issue: nxt = ST_WB;
            st_wb:    nxt = ST_IDLE;
            default:  nxt = ST_IDLE;
        endcase
    end

    always_comb begin
        cif.cmd_ready = st_idle;
        cif.rsp_valid = st_wb | rd_pend;
        cif.rsp_data  = st_wb ? fu_f : rd_data_q;
        rf_ra = (cif.cmd_kind == CMD_READ) ? cif.cmd_rd
                                           : cif.cmd_ra;
        // LOADI is only accepted in IDLE, so it never meets WB
        rf_we = st_wb | k_loadi;
        rf_wa = st_wb ? rd_q : cif.cmd_rd;
        rf_wd = st_wb ? fu_f : cif.cmd_imm;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            fu_op     <= '0;
            fu_a      <= '0;
            fu_b      <= '0;
            rd_q      <= '0;
            flags     <= '0;
            rd_pend   <= 1'b0;
            rd_data_q <= '0;
        end else begin
            rd_pend <= k_read;
            if (k_read) begin
                rd_data_q <= rf_da;
            end
            if (k_exec) begin
                fu_op <= cif.cmd_op;
                fu_a  <= rf_da;
                fu_b  <= rf_db;
                rd_q  <= cif.cmd_rd;
            end
            if (st_wb) begin
                flags <= pack_flags(fu_n, fu_c, fu_v, fu_z);
            end
        end
    end

    fu_regfile #(
        .DSIZE (DSIZE),
        .AW    (AW)
    ) u_rf (
        .clk   (clk),
        .rst_n (rst_n),
        .ra_a  (rf_ra),
        .ra_b  (cif.cmd_rb),
        .rd_a  (rf_da),
        .rd_b  (rf_db),
        .we    (rf_we),
        .wa    (rf_wa),
        .wd    (rf_wd)
    );

endmodule

// File: tb/tb_fu_ctrl.sv
// Self-checking bench for fu_ctrl with a behavioural functional unit
// and a register-file/flags reference model.
module tb_fu_ctrl;
    import fu_pkg::*;

    localparam int OPSIZE = 5;
    localparam int DSIZE  = 16;
    localparam int AW     = 3;
    localparam int NREG   = 8;

    localparam logic [4:0] OP_ADD = 5'h00;
    localparam logic [4:0] OP_SUB = 5'h01;
    localparam logic [4:0] OP_AND = 5'h02;
    localparam logic [4:0] OP_XOR = 5'h03;
    localparam logic [4:0] OP_SHL = 5'h10;
    localparam logic [4:0] OP_SHR = 5'h11;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    fu_ctrl_if #(.OPSIZE(OPSIZE), .DSIZE(DSIZE), .AW(AW)) bus ();

    logic [3:0]  flags;
    logic [4:0]  fu_op;
    logic [15:0] fu_a;
    logic [15:0] fu_b;
    logic [15:0] fu_f;
    logic        fu_n;
    logic        fu_c;
    logic        fu_v;
    logic        fu_z;

    fu_ctrl #(.OPSIZE(OPSIZE), .DSIZE(DSIZE), .AW(AW)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .cif   (bus),
        .flags (flags),
        .fu_op (fu_op),
        .fu_a  (fu_a),
        .fu_b  (fu_b),
        .fu_f  (fu_f),
        .fu_n  (fu_n),
        .fu_c  (fu_c),
        .fu_v  (fu_v),
        .fu_z  (fu_z)
    );

    // Returns {N,C,V,Z,result} from plain integer arithmetic
    function automatic logic [19:0] fu_calc(input logic [4:0] op,
                                            input logic [15:0] a,
                                            input logic [15:0] b);
        int sa;
        int sb;
        int ua;
        int ub;
        logic [15:0] f;
        logic n;
        logic c;
        logic v;
        sa = $signed(a);
        sb = $signed(b);
        ua = int'(a);
        ub = int'(b);
        f = '0;
        c = 1'b0;
        v = 1'b0;
        case (op)
            OP_ADD: begin
                f = a + b;
                c = (ua + ub) > 65535;
                v = ((sa + sb) > 32767) || ((sa + sb) < -32768);
            end
            OP_SUB: begin
                f = a - b;
                c = ua < ub;
                v = ((sa - sb) > 32767) || ((sa - sb) < -32768);
            end
            OP_AND: f = a & b;
            OP_XOR: f = a ^ b;
            OP_SHL: f = a << b[3:0];
            OP_SHR: f = a >> b[3:0];
            default: f = '0;
        endcase
        n = op[4] ? 1'b0 : f[15];
        return {n, c, v, (f == 16'h0000), f};
    endfunction

    always @(posedge clk) begin
        {fu_n, fu_c, fu_v, fu_z, fu_f} <= fu_calc(fu_op, fu_a, fu_b);
    end

    logic [15:0] m_rf [NREG];
    logic [3:0]  m_flags;
    logic [15:0] last_rsp;
    int total = 0;
    int bad = 0;
    logic [4:0] ops [6];

    task automatic set_cmd(input logic [1:0] kind, input logic [4:0] op,
                           input logic [2:0] ra, input logic [2:0] rb,
                           input logic [2:0] rd, input logic [15:0] imm);
        bus.cmd_kind = kind;
        bus.cmd_op   = op;
        bus.cmd_ra   = ra;
        bus.cmd_rb   = rb;
        bus.cmd_rd   = rd;
        bus.cmd_imm  = imm;
    endtask

    task automatic wait_accept(input string nm);
        int n;
        n = 0;
        while (bus.cmd_ready !== 1'b1 && n < 20) begin
            @(negedge clk);
            n++;
        end
        total++;
        if (n >= 20) begin
            bad++;
            $display("FAIL %s_accept: cmd_ready got %b want 1", nm,
                     bus.cmd_ready);
        end
        @(posedge clk);
        #1;
    endtask

    task automatic loadi_cmd(input logic [2:0] rd, input logic [15:0] imm);
        @(negedge clk);
        set_cmd(CMD_LOADI, 5'h0, 3'd0, 3'd0, rd, imm);
        bus.cmd_valid = 1'b1;
        wait_accept("loadi");
        bus.cmd_valid = 1'b0;
        m_rf[rd] = imm;
    endtask

    task automatic read_cmd(input logic [2:0] rd);
        @(negedge clk);
        set_cmd(CMD_READ, 5'h0, 3'd0, 3'd0, rd, 16'h0);
        bus.cmd_valid = 1'b1;
        wait_accept("read");
        bus.cmd_valid = 1'b0;
        @(negedge clk);
        total++;
        if (bus.rsp_valid !== 1'b1 || bus.rsp_data !== m_rf[rd]) begin
            bad++;
            $display("FAIL read_r%0d: got v=%b d=%h want v=1 d=%h", rd,
                     bus.rsp_valid, bus.rsp_data, m_rf[rd]);
        end
        last_rsp = bus.rsp_data;
        @(negedge clk);
        total++;
        if (bus.rsp_valid !== 1'b0) begin
            bad++;
            $display("FAIL read_pulse: rsp_valid got %b want 0",
                     bus.rsp_valid);
        end
    endtask

    task automatic exec_cmd(input logic [4:0] op, input logic [2:0] ra,
                            input logic [2:0] rb, input logic [2:0] rd);
        logic [19:0] exp;
        exp = fu_calc(op, m_rf[ra], m_rf[rb]);
        @(negedge clk);
        set_cmd(CMD_EXEC, op, ra, rb, rd, 16'h0);
        bus.cmd_valid = 1'b1;
        wait_accept("exec");
        bus.cmd_valid = 1'b0;
        @(negedge clk);
        total++;
        if (bus.rsp_valid !== 1'b0 || bus.cmd_ready !== 1'b0) begin
            bad++;
            $display("FAIL exec_issue: got v=%b rdy=%b want v=0 rdy=0",
                     bus.rsp_valid, bus.cmd_ready);
        end
        @(negedge clk);
        total++;
        if (bus.rsp_valid !== 1'b1 || bus.rsp_data !== exp[15:0]) begin
            bad++;
            $display("FAIL exec_wb: got v=%b d=%h want v=1 d=%h",
                     bus.rsp_valid, bus.rsp_data, exp[15:0]);
        end
        last_rsp = bus.rsp_data;
        @(posedge clk);
        #1;
        m_rf[rd] = exp[15:0];
        m_flags = exp[19:16];
        total++;
        if (flags !== m_flags || bus.cmd_ready !== 1'b1) begin
            bad++;
            $display("FAIL exec_flags: got fl=%b rdy=%b want fl=%b rdy=1",
                     flags, bus.cmd_ready, m_flags);
        end
    endtask

    task automatic rsvd_cmd();
        @(negedge clk);
        set_cmd(CMD_RSVD, 5'h1f, 3'd1, 3'd2, 3'd3, 16'hdead);
        bus.cmd_valid = 1'b1;
        wait_accept("rsvd");
        bus.cmd_valid = 1'b0;
        @(negedge clk);
        total++;
        if (bus.rsp_valid !== 1'b0 || bus.cmd_ready !== 1'b1
            || flags !== m_flags) begin
            bad++;
            $display("FAIL rsvd: got v=%b rdy=%b fl=%b want 0 1 %b",
                     bus.rsp_valid, bus.cmd_ready, flags, m_flags);
        end
    endtask

    task automatic model_reset();
        for (int i = 0; i < NREG; i++) m_rf[i] = 16'h0;
        m_flags = 4'h0;
    endtask

    task automatic test_reset();
        bus.cmd_valid = 1'b0;
        set_cmd(CMD_EXEC, 5'h0, 3'd0, 3'd0, 3'd0, 16'h0);
        model_reset();
        rst_n = 1'b0;
        repeat (2) @(negedge clk);
        total++;
        if (bus.cmd_ready !== 1'b1 || bus.rsp_valid !== 1'b0
            || bus.rsp_data !== 16'h0 || flags !== 4'h0) begin
            bad++;
            $display("FAIL reset_out: rdy=%b v=%b d=%h fl=%b want 1 0 0 0",
                     bus.cmd_ready, bus.rsp_valid, bus.rsp_data, flags);
        end
        total++;
        if (fu_op !== 5'h0 || fu_a !== 16'h0 || fu_b !== 16'h0) begin
            bad++;
            $display("FAIL reset_fu: op=%h a=%h b=%h want 0 0 0",
                     fu_op, fu_a, fu_b);
        end
        rst_n = 1'b1;
        @(negedge clk);
    endtask

    task automatic test_add();
        loadi_cmd(3'd1, 16'h0005);
        loadi_cmd(3'd2, 16'h0003);
        exec_cmd(OP_ADD, 3'd1, 3'd2, 3'd3);
        total++;
        if (last_rsp !== 16'h0008 || flags !== 4'b0000) begin
            bad++;
            $display("FAIL add_const: d=%h fl=%b want 0008 0000",
                     last_rsp, flags);
        end
        read_cmd(3'd3);
        total++;
        if (last_rsp !== 16'h0008) begin
            bad++;
            $display("FAIL add_read: got %h want 0008", last_rsp);
        end
    endtask

    task automatic test_overflow();
        loadi_cmd(3'd1, 16'h7fff);
        loadi_cmd(3'd2, 16'h0001);
        exec_cmd(OP_ADD, 3'd1, 3'd2, 3'd4);
        total++;
        if (last_rsp !== 16'h8000 || flags !== 4'b1010) begin
            bad++;
            $display("FAIL ovf_const: d=%h fl=%b want 8000 1010",
                     last_rsp, flags);
        end
    endtask

    task automatic test_same_reg();
        loadi_cmd(3'd1, 16'h1234);
        exec_cmd(OP_SUB, 3'd1, 3'd1, 3'd1);
        total++;
        if (last_rsp !== 16'h0000 || flags[FLAG_Z] !== 1'b1) begin
            bad++;
            $display("FAIL same_reg: d=%h z=%b want 0000 1",
                     last_rsp, flags[FLAG_Z]);
        end
        read_cmd(3'd1);
    endtask

    task automatic test_reset_mid_exec();
        @(negedge clk);
        set_cmd(CMD_EXEC, OP_ADD, 3'd3, 3'd4, 3'd5, 16'h0);
        bus.cmd_valid = 1'b1;
        wait_accept("rst_exec");
        bus.cmd_valid = 1'b0;
        @(negedge clk);
        rst_n = 1'b0;
        #1;
        total++;
        if (bus.rsp_valid !== 1'b0 || flags !== 4'h0 || fu_a !== 16'h0
            || fu_b !== 16'h0 || fu_op !== 5'h0) begin
            bad++;
            $display("FAIL rst_mid: v=%b fl=%b a=%h b=%h want 0",
                     bus.rsp_valid, flags, fu_a, fu_b);
        end
        model_reset();
        @(negedge clk);
        rst_n = 1'b1;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            total++;
            if (bus.rsp_valid !== 1'b0 || bus.cmd_ready !== 1'b1
                || flags !== 4'h0) begin
                bad++;
                $display("FAIL rst_after%0d: v=%b rdy=%b fl=%b want 0 1 0",
                         i, bus.rsp_valid, bus.cmd_ready, flags);
            end
        end
        for (int i = 0; i < NREG; i++) read_cmd(3'(i));
    endtask

    task automatic test_shift_hold();
        loadi_cmd(3'd2, 16'h0001);
        loadi_cmd(3'd4, 16'h000f);
        @(negedge clk);
        set_cmd(CMD_EXEC, OP_SHL, 3'd2, 3'd4, 3'd6, 16'h0);
        bus.cmd_valid = 1'b1;
        wait_accept("shift");
        set_cmd(CMD_LOADI, 5'h0, 3'd0, 3'd0, 3'd5, 16'hbeef);
        @(negedge clk);
        total++;
        if (bus.cmd_ready !== 1'b0 || bus.rsp_valid !== 1'b0) begin
            bad++;
            $display("FAIL hold_issue: rdy=%b v=%b want 0 0",
                     bus.cmd_ready, bus.rsp_valid);
        end
        @(negedge clk);
        total++;
        if (bus.cmd_ready !== 1'b0 || bus.rsp_valid !== 1'b1
            || bus.rsp_data !== 16'h8000) begin
            bad++;
            $display("FAIL hold_wb: rdy=%b v=%b d=%h want 0 1 8000",
                     bus.cmd_ready, bus.rsp_valid, bus.rsp_data);
        end
        @(posedge clk);
        #1;
        total++;
        if (flags !== 4'b0000) begin
            bad++;
            $display("FAIL shift_flags: got %b want 0000", flags);
        end
        m_rf[6] = 16'h8000;
        m_flags = 4'b0000;
        @(posedge clk);
        #1;
        bus.cmd_valid = 1'b0;
        m_rf[5] = 16'hbeef;
        total++;
        if (bus.rsp_valid !== 1'b0 || bus.cmd_ready !== 1'b1) begin
            bad++;
            $display("FAIL hold_load: v=%b rdy=%b want 0 1",
                     bus.rsp_valid, bus.cmd_ready);
        end
        read_cmd(3'd6);
        read_cmd(3'd5);
    endtask

    task automatic test_back_to_back();
        logic [15:0] imm;
        for (int i = 0; i < NREG; i++) begin
            @(negedge clk);
            imm = 16'($urandom);
            set_cmd(CMD_LOADI, 5'h0, 3'd0, 3'd0, 3'(i), imm);
            bus.cmd_valid = 1'b1;
            total++;
            if (bus.cmd_ready !== 1'b1 || bus.rsp_valid !== 1'b0) begin
                bad++;
                $display("FAIL b2b_load%0d: rdy=%b v=%b want 1 0",
                         i, bus.cmd_ready, bus.rsp_valid);
            end
            m_rf[i] = imm;
        end
        for (int i = 0; i <= NREG; i++) begin
            @(negedge clk);
            if (i > 0) begin
                total++;
                if (bus.rsp_valid !== 1'b1
                    || bus.rsp_data !== m_rf[i-1]) begin
                    bad++;
                    $display("FAIL b2b_read%0d: v=%b d=%h want 1 %h",
                             i - 1, bus.rsp_valid, bus.rsp_data,
                             m_rf[i-1]);
                end
            end
            if (i < NREG) begin
                set_cmd(CMD_READ, 5'h0, 3'd0, 3'd0, 3'(i), 16'h0);
            end else begin
                bus.cmd_valid = 1'b0;
            end
        end
        @(negedge clk);
        total++;
        if (bus.rsp_valid !== 1'b0) begin
            bad++;
            $display("FAIL b2b_end: v=%b want 0", bus.rsp_valid);
        end
        rsvd_cmd();
        read_cmd(3'd3);
    endtask

    task automatic test_random();
        ops = '{OP_ADD, OP_SUB, OP_AND, OP_XOR, OP_SHL, OP_SHR};
        for (int i = 0; i < 60; i++) begin
            case ($urandom_range(0, 3))
                0: exec_cmd(ops[$urandom_range(0, 5)],
                            3'($urandom), 3'($urandom), 3'($urandom));
                1: loadi_cmd(3'($urandom), 16'($urandom));
                2: read_cmd(3'($urandom));
                default: rsvd_cmd();
            endcase
        end
        for (int i = 0; i < NREG; i++) read_cmd(3'(i));
    endtask

    initial begin
        #400000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    initial begin
        test_reset();
        test_add();
        test_overflow();
        test_same_reg();
        test_reset_mid_exec();
        test_shift_hold();
        test_back_to_back();
        test_random();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
